// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory bus controller.
// Arbitrates instruction fetch and data access onto an 8-bit bus.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        dm_req_i,
    input  logic        dm_wr_i,
    input  logic [1:0]  dm_size_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_done_o,
    output logic [31:0] dm_rdata_o,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        REPLAY
    } state_e;

    state_e      state_q;
    logic [31:0] base_q;
    logic [31:0] a_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] if_data_q;
    logic [31:0] dm_data_q;
    logic [7:0]  dout_q;
    logic        wr_q;
    logic        is_if_q;
    logic [2:0]  n_q;
    logic [1:0]  off_q;
    logic [1:0]  cap_q;
    logic        drv_q;
    logic        vld_q;
    logic        rdy_q;
    logic        if_done_q;
    logic        dm_done_q;

    logic [2:0]  n_dm;
    logic        rd_st;
    logic        resume;
    logic [1:0]  eff_off;
    logic        eff_drv;
    logic        eff_vld;
    logic [1:0]  nxt_off;
    logic        more;
    logic        last_cap;
    logic [31:0] buf_d;
    logic [1:0]  woff;
    logic        wr_more;
    logic [7:0]  wnext;

    // Byte count of a data access; size 11 is treated as a word.
    always_comb begin
        n_dm = 3'd4;
        unique case (dm_size_i)
            2'b00:   n_dm = 3'd1;
            2'b01:   n_dm = 3'd2;
            default: n_dm = 3'd4;
        endcase
    end

    // First granted cycle after a stall during a read re-drives the
    // oldest byte whose data has not been captured yet.
    assign rd_st   = (state_q == READ) || (state_q == REPLAY);
    assign resume  = rd_st & rdy_in & ~rdy_q;
    assign eff_off = resume ? cap_q : off_q;
    assign eff_drv = resume | drv_q;
    assign eff_vld = ~resume & vld_q;
    assign nxt_off = eff_off + 2'd1;
    assign more    = ({1'b0, eff_off} + 3'd1) < n_q;
    assign last_cap = eff_vld && (({1'b0, cap_q} + 3'd1) == n_q);

    assign woff    = off_q + 2'd1;
    assign wr_more = ({1'b0, off_q} + 3'd1) < n_q;
    assign wnext   = wdata_q[{woff, 3'b000} +: 8];

    // Read assembly buffer with the byte arriving this cycle merged in.
    always_comb begin
        buf_d = buf_q;
        buf_d[{cap_q, 3'b000} +: 8] = mem_din;
    end

    assign mem_a      = resume ? base_q + {30'd0, cap_q} : a_q;
    assign mem_wr     = wr_q & rdy_in & ~rst_in;
    assign mem_dout   = dout_q;
    assign if_done_o  = if_done_q;
    assign if_data_o  = if_data_q;
    assign dm_done_o  = dm_done_q;
    assign dm_rdata_o = dm_data_q;

    // Transfer FSM: accept, stream bytes, capture, complete.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            base_q    <= '0;
            a_q       <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            if_data_q <= '0;
            dm_data_q <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            is_if_q   <= 1'b0;
            n_q       <= '0;
            off_q     <= '0;
            cap_q     <= '0;
            drv_q     <= 1'b0;
            vld_q     <= 1'b0;
            rdy_q     <= 1'b1;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
        end else begin
            rdy_q     <= rdy_in;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            if (rdy_in) begin
                case (state_q)
                    IDLE: begin
                        if (!if_done_q && !dm_done_q) begin
                            if (dm_req_i) begin
                                base_q  <= dm_addr_i;
                                a_q     <= dm_addr_i;
                                n_q     <= n_dm;
                                wdata_q <= dm_wdata_i;
                                is_if_q <= 1'b0;
                                off_q   <= '0;
                                cap_q   <= '0;
                                buf_q   <= '0;
                                vld_q   <= 1'b0;
                                if (dm_wr_i) begin
                                    state_q <= WRITE;
                                    wr_q    <= 1'b1;
                                    dout_q  <= dm_wdata_i[7:0];
                                    drv_q   <= 1'b0;
                                end else begin
                                    state_q <= READ;
                                    drv_q   <= 1'b1;
                                end
                            end else if (if_req_i) begin
                                base_q  <= if_addr_i;
                                a_q     <= if_addr_i;
                                n_q     <= 3'd4;
                                is_if_q <= 1'b1;
                                off_q   <= '0;
                                cap_q   <= '0;
                                buf_q   <= '0;
                                vld_q   <= 1'b0;
                                drv_q   <= 1'b1;
                                state_q <= READ;
                            end
                        end
                    end
                    READ, REPLAY: begin
                        state_q <= resume ? REPLAY : READ;
                        if (eff_vld) begin
                            buf_q <= buf_d;
                            cap_q <= cap_q + 2'd1;
                        end
                        vld_q <= eff_drv;
                        if (eff_drv && more) begin
                            off_q <= nxt_off;
                            a_q   <= base_q + {30'd0, nxt_off};
                            drv_q <= 1'b1;
                        end else begin
                            off_q <= eff_off;
                            a_q   <= base_q + {30'd0, eff_off};
                            drv_q <= 1'b0;
                        end
                        if (last_cap) begin
                            state_q <= IDLE;
                            vld_q   <= 1'b0;
                            drv_q   <= 1'b0;
                            if (is_if_q) begin
                                if_data_q <= buf_d;
                                if_done_q <= 1'b1;
                            end else begin
                                dm_data_q <= buf_d;
                                dm_done_q <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        if (wr_more) begin
                            off_q  <= woff;
                            a_q    <= base_q + {30'd0, woff};
                            dout_q <= wnext;
                        end else begin
                            wr_q      <= 1'b0;
                            state_q   <= IDLE;
                            dm_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl
// against a byte-array memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        dm_req_i;
    logic        dm_wr_i;
    logic [1:0]  dm_size_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_done_o;
    logic [31:0] dm_rdata_o;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0] ram [0:4095];
    logic [7:0] ref_mem [0:4095];
    wr_t        wlog [$];
    int         n_chk = 0;
    int         n_pass = 0;

    mem_ctrl dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_done_o  (if_done_o),
        .if_data_o  (if_data_o),
        .dm_req_i   (dm_req_i),
        .dm_wr_i    (dm_wr_i),
        .dm_size_i  (dm_size_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_done_o  (dm_done_o),
        .dm_rdata_o (dm_rdata_o),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_b(input logic [11:0] i);
        case (i)
            12'h100: return 8'h11;
            12'h101: return 8'h22;
            12'h102: return 8'h33;
            12'h103: return 8'h44;
            12'h040: return 8'hFF;
            default: return i[7:0] ^ {i[11:8], i[11:8]} ^ 8'h5A;
        endcase
    endfunction

    // Bus-side RAM (4 KiB, aliased); garbage on mem_din while the host owns the bus.
    always @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_b(12'(i));
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wlog.push_back(wr_t'({mem_a, mem_dout}));
        end
        if (!rdy_in) mem_din <= 8'($urandom);
        else mem_din <= ram[mem_a[11:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input bit is_if, input bit wr,
                           input logic [1:0] sz, input logic [31:0] ad,
                           input logic [31:0] wd, input bit stall,
                           output logic [31:0] rd, output int lat);
        rd  = '0;
        lat = -1;
        if (is_if) begin
            if_req_i  = 1'b1;
            if_addr_i = ad;
        end else begin
            dm_req_i   = 1'b1;
            dm_wr_i    = wr;
            dm_size_i  = sz;
            dm_addr_i  = ad;
            dm_wdata_i = wd;
        end
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (stall) rdy_in = ($urandom_range(0, 3) != 0);
            #1;
            if (is_if ? if_done_o : dm_done_o) begin
                rd  = is_if ? if_data_o : dm_rdata_o;
                lat = c;
                break;
            end
        end
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        rdy_in   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        rdy_in = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_wr_i = 1'b0; dm_size_i = '0;
        dm_addr_i = '0; dm_wdata_i = '0;
        repeat (3) tick();
        #1;
        n_chk++;
        if (mem_a !== 32'h0) $display("FAIL rst_mem_a got %h want 0", mem_a);
        else n_pass++;
        n_chk++;
        if (mem_dout !== 8'h0) $display("FAIL rst_mem_dout got %h want 0", mem_dout);
        else n_pass++;
        n_chk++;
        if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr got %b want 0", mem_wr);
        else n_pass++;
        n_chk++;
        if ({if_done_o, dm_done_o} !== 2'b00)
            $display("FAIL rst_done got %b want 00", {if_done_o, dm_done_o});
        else n_pass++;
        n_chk++;
        if ({if_data_o, dm_rdata_o} !== 64'h0)
            $display("FAIL rst_data got %h %h want 0", if_data_o, dm_rdata_o);
        else n_pass++;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        int done_at = 0;
        int dones = 0;
        int wrs = 0;
        logic [31:0] rd = '0;
        dm_req_i = 1'b1; dm_wr_i = 1'b0; dm_size_i = 2'b10;
        dm_addr_i = 32'h100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            if (k <= 4) begin
                n_chk++;
                if (mem_a !== 32'h100 + 32'(k - 1))
                    $display("FAIL lw_addr k=%0d got %h want %h", k, mem_a, 32'h100 + 32'(k - 1));
                else n_pass++;
            end
            if (mem_wr) wrs++;
            if (dm_done_o) begin
                dones++;
                if (done_at == 0) done_at = k;
                rd = dm_rdata_o;
                dm_req_i = 1'b0;
            end
        end
        n_chk++;
        if (done_at != 6 || dones != 1)
            $display("FAIL lw_done got at %0d x%0d want at 6 x1", done_at, dones);
        else n_pass++;
        n_chk++;
        if (rd !== 32'h44332211) $display("FAIL lw_data got %h want 44332211", rd);
        else n_pass++;
        n_chk++;
        if (wrs != 0) $display("FAIL lw_nowrite got %0d want 0", wrs);
        else n_pass++;
        tick();
    endtask

    task automatic test_sh();
        int done_at = 0;
        int wrs = 0;
        dm_req_i = 1'b1; dm_wr_i = 1'b1; dm_size_i = 2'b01;
        dm_addr_i = 32'h202; dm_wdata_i = 32'h0000ABCD;
        #1;
        n_chk++;
        if (mem_wr !== 1'b0) $display("FAIL sh_accept_wr got %b want 0", mem_wr);
        else n_pass++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1;
            if (mem_wr) wrs++;
            if (k == 1) begin
                n_chk++;
                if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h202, 8'hCD})
                    $display("FAIL sh_b0 got %b %h %h want 1 202 cd", mem_wr, mem_a, mem_dout);
                else n_pass++;
            end
            if (k == 2) begin
                n_chk++;
                if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h203, 8'hAB})
                    $display("FAIL sh_b1 got %b %h %h want 1 203 ab", mem_wr, mem_a, mem_dout);
                else n_pass++;
            end
            if (dm_done_o) begin
                if (done_at == 0) done_at = k;
                dm_req_i = 1'b0;
            end
        end
        n_chk++;
        if (done_at != 3) $display("FAIL sh_done got %0d want 3", done_at);
        else n_pass++;
        n_chk++;
        if (wrs != 2) $display("FAIL sh_wrcount got %0d want 2", wrs);
        else n_pass++;
        tick();
    endtask

    task automatic test_arb();
        int dm_at = 0;
        int if_at = 0;
        logic [31:0] dr = '0;
        logic [31:0] ir = '0;
        logic [31:0] iexp;
        iexp = {init_b(12'h3), init_b(12'h2), init_b(12'h1), init_b(12'h0)};
        if_req_i = 1'b1; if_addr_i = 32'h0;
        dm_req_i = 1'b1; dm_wr_i = 1'b0; dm_size_i = 2'b00;
        dm_addr_i = 32'h30000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            #1;
            if (k == 1) begin
                n_chk++;
                if (mem_a !== 32'h30000) $display("FAIL arb_first got %h want 00030000", mem_a);
                else n_pass++;
            end
            if (k == 5) begin
                n_chk++;
                if (mem_a !== 32'h0) $display("FAIL arb_fetch_addr got %h want 0", mem_a);
                else n_pass++;
            end
            if (dm_done_o && dm_at == 0) begin
                dm_at = k; dr = dm_rdata_o; dm_req_i = 1'b0;
            end
            if (if_done_o && if_at == 0) begin
                if_at = k; ir = if_data_o; if_req_i = 1'b0;
            end
        end
        n_chk++;
        if (dm_at != 3 || if_at != 10)
            $display("FAIL arb_timing got dm %0d if %0d want dm 3 if 10", dm_at, if_at);
        else n_pass++;
        n_chk++;
        if (dr !== {24'h0, init_b(12'h0)})
            $display("FAIL arb_lb_data got %h want %h", dr, {24'h0, init_b(12'h0)});
        else n_pass++;
        n_chk++;
        if (ir !== iexp) $display("FAIL arb_fetch_data got %h want %h", ir, iexp);
        else n_pass++;
        tick();
    endtask

    task automatic test_lb_ff();
        logic [31:0] rd;
        int lat;
        run_txn(1'b0, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, rd, lat);
        n_chk++;
        if (rd !== 32'h000000FF || lat != 3)
            $display("FAIL lb_ff got %h lat %0d want 000000ff lat 3", rd, lat);
        else n_pass++;
    endtask

    task automatic test_stall_read();
        int done_at = 0;
        int wrs = 0;
        logic [31:0] rd = '0;
        dm_req_i = 1'b1; dm_wr_i = 1'b0; dm_size_i = 2'b10;
        dm_addr_i = 32'h100;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 3) rdy_in = 1'b0;
            if (k == 6) rdy_in = 1'b1;
            #1;
            if (mem_wr) wrs++;
            if (k == 2 || k == 4 || k == 6) begin
                n_chk++;
                if (mem_a !== (k == 4 ? 32'h102 : 32'h101))
                    $display("FAIL stall_addr k=%0d got %h want %h", k, mem_a,
                             (k == 4 ? 32'h102 : 32'h101));
                else n_pass++;
            end
            if (dm_done_o && done_at == 0) begin
                done_at = k; rd = dm_rdata_o; dm_req_i = 1'b0;
            end
        end
        n_chk++;
        if (done_at != 10) $display("FAIL stall_done got %0d want 10", done_at);
        else n_pass++;
        n_chk++;
        if (rd !== 32'h44332211 || wrs != 0)
            $display("FAIL stall_data got %h wr %0d want 44332211 wr 0", rd, wrs);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int w0;
        int late = 0;
        w0 = wlog.size();
        dm_req_i = 1'b1; dm_wr_i = 1'b1; dm_size_i = 2'b10;
        dm_addr_i = 32'h300; dm_wdata_i = 32'hDEADBEEF;
        tick();
        #1;
        n_chk++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'hEF})
            $display("FAIL rstw_b0 got %b %h %h want 1 300 ef", mem_wr, mem_a, mem_dout);
        else n_pass++;
        tick();
        rst_in = 1'b1;
        dm_req_i = 1'b0;
        #1;
        n_chk++;
        if (mem_wr !== 1'b0) $display("FAIL rstw_gate got %b want 0", mem_wr);
        else n_pass++;
        tick();
        rst_in = 1'b0;
        #1;
        n_chk++;
        if ({mem_a, mem_dout, mem_wr, if_done_o, dm_done_o, if_data_o, dm_rdata_o} !== '0)
            $display("FAIL rstw_outs got a %h d %h w %b done %b%b data %h %h want 0",
                     mem_a, mem_dout, mem_wr, if_done_o, dm_done_o, if_data_o, dm_rdata_o);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            if (dm_done_o || mem_wr) late++;
        end
        n_chk++;
        if (late != 0) $display("FAIL rstw_after got %0d events want 0", late);
        else n_pass++;
        n_chk++;
        if (wlog.size() - w0 != 1 || wlog[w0] !== wr_t'({32'h300, 8'hEF}))
            $display("FAIL rstw_log got %0d writes want 1", wlog.size() - w0);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_b(12'(i));
        for (int t = 0; t < 60; t++) begin
            bit          stall;
            bit          is_if;
            bit          wr;
            logic [1:0]  sz;
            logic [31:0] ad;
            logic [31:0] wd;
            logic [31:0] exp_rd;
            logic [31:0] rd;
            logic [31:0] x;
            int          n;
            int          lat;
            int          w0;
            int          kind;
            bit          ok;
            stall = (t >= 30);
            kind  = $urandom_range(0, 2);
            is_if = (kind == 0);
            wr    = (kind == 2);
            sz    = 2'($urandom_range(0, 3));
            ad    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                                : 32'h1080 + $urandom_range(0, 23);
            wd    = $urandom;
            n     = is_if ? 4 : (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4));
            exp_rd = '0;
            for (int k = 0; k < n; k++) begin
                x = ad + 32'(k);
                exp_rd[8*k +: 8] = ref_mem[x[11:0]];
            end
            w0 = wlog.size();
            run_txn(is_if, wr, sz, ad, wd, stall, rd, lat);
            n_chk++;
            if (lat < 0) $display("FAIL rnd_timeout t=%0d", t);
            else n_pass++;
            if (!stall) begin
                n_chk++;
                if (lat != (wr ? n + 1 : n + 2))
                    $display("FAIL rnd_latency t=%0d got %0d want %0d", t, lat, wr ? n + 1 : n + 2);
                else n_pass++;
            end
            if (!wr) begin
                n_chk++;
                if (rd !== exp_rd)
                    $display("FAIL rnd_rdata t=%0d addr %h got %h want %h", t, ad, rd, exp_rd);
                else n_pass++;
            end
            ok = (wlog.size() - w0 == (wr ? n : 0));
            if (ok && wr) begin
                for (int k = 0; k < n; k++) begin
                    x = ad + 32'(k);
                    if (wlog[w0 + k] !== wr_t'({x, wd[8*k +: 8]})) ok = 1'b0;
                    ref_mem[x[11:0]] = wd[8*k +: 8];
                end
            end
            n_chk++;
            if (!ok)
                $display("FAIL rnd_writes t=%0d addr %h got %0d writes want %0d",
                         t, ad, wlog.size() - w0, wr ? n : 0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sh();
        test_arb();
        test_lb_ff();
        test_stall_read();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 No parameters; bus address width fixed at 32, data path fixed at 8 bits.
REQ-002 clk_in  input  1  single clock, all state on rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 rdy_in  input  1  bus grant; low = bus taken by host debug interface, controller stalls.
REQ-005 if_req_i  input  1  instruction fetch request (4-byte read), held until if_done_o.
REQ-006 if_addr_i  input  32  fetch address.
REQ-007 if_done_o  output  1  one-cycle pulse, if_data_o valid.
REQ-008 if_data_o  output  32  fetched word, little-endian.
REQ-009 dm_req_i  input  1  data request, held until dm_done_o.
REQ-010 dm_wr_i  input  1  1 = store, 0 = load.
REQ-011 dm_size_i  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-012 dm_addr_i  input  32  data address, any alignment.
REQ-013 dm_wdata_i  input  32  store data, low bytes used.
REQ-014 dm_done_o  output  1  one-cycle pulse, access complete.
REQ-015 dm_rdata_o  output  32  load data, zero-extended (sign extension is the LSU's job).
REQ-016 mem_din  input  8  bus read data, valid one cycle after address driven.
REQ-017 mem_dout  output  8  bus write data.
REQ-018 mem_a  output  32  bus byte address.
REQ-019 mem_wr  output  1  1 = write this cycle.

Function
REQ-020 States: IDLE, READ, WRITE, REPLAY; requests sampled only in IDLE.
REQ-021 IDLE arbitration: dm_req_i beats if_req_i; active transfer never preempted; loser stays pending.
REQ-022 n = bytes (fetch 4; data per dm_size_i); byte k at mem_a = addr+k modulo 2^32, data bits [8k+7:8k].
REQ-023 Accept cycle T: transfer params registered; byte k driven on mem_a in cycle T+1+k.
REQ-024 Read: mem_din captured in cycle T+2+k into byte k; done pulse and data valid in cycle T+n+2.
REQ-025 Write: mem_wr=1, mem_dout=byte k in cycle T+1+k; done pulse in cycle T+n+1.
REQ-026 mem_wr=0 in IDLE, READ, REPLAY and whenever rdy_in=0.
REQ-027 Done pulse cycle returns to IDLE; request still high in following cycle = new request.
REQ-028 if_data_o/dm_rdata_o hold last value until next read completes; upper unread bytes 0.
REQ-029 rdy_in=0: all state frozen, no capture, no address advance, no write issued.
REQ-030 rdy_in 0->1 during READ: enter REPLAY, re-drive oldest uncaptured byte address, capture from next cycle; total delay = stall cycles + 1.
REQ-031 rdy_in 0->1 during WRITE: resume with first unissued byte; no byte written twice (IO at 0x30000 side-effect safe).
REQ-032 rdy_in low in IDLE: no request accepted.

Reset
REQ-033 rst_in high: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, both done=0, both data outputs 0.
REQ-034 Reset mid-transfer aborts it: no done pulse, no further writes, pending requests dropped.
REQ-035 Reset dominates rdy_in.

Verification
REQ-036 lw 0x100, RAM 11,22,33,44, accept T -> mem_a 0x100..0x103 at T+1..T+4, dm_done_o at T+6, dm_rdata_o 0x44332211.
REQ-037 sh 0x0000ABCD to 0x202 -> mem_wr=1 at T+1 (0x202, CD), T+2 (0x203, AB), dm_done_o at T+3, mem_wr 0 elsewhere.
REQ-038 if_req_i (0x0) and lb 0x30000 same cycle T -> lb first, dm_done_o T+3; fetch accepted T+4, if_done_o T+10.
REQ-039 lb returning 0xFF -> dm_rdata_o 0x000000FF.
REQ-040 Word read, rdy_in low 3 cycles after byte 1 driven -> byte 1 re-driven on resume, data correct, done 4 cycles late.
REQ-041 rst_in at T+2 of a sw -> only byte 0 written, no dm_done_o, all outputs 0 next cycle.
